chorus_delay_ctrl: RTL and testbench
====================================

// Module: chorus_delay_ctrl
// PURPOSE
//  Initiator side of the chorus delay-line RAM (ram_1r1w_sync). Accepts audio samples, writes them
//  into a circular buffer and reads back the sample "delay" entries older.
//  The delay is base_delay_i plus a triangle LFO offset. Emits the wet (or dry/wet mixed) sample.
//  Sits between the audio input stream and the chorus output stage.
// PARAMETERS
//  width_p  16   sample width, signed two's complement
//  depth_p  512  delay-line entries; power of 2; must match the attached RAM
// PORTS
//  clk_i           in  1                  single clock
//  reset_i         in  1                  synchronous, active-high reset
//  valid_i         in  1                  input sample valid
//  ready_o         out 1                  block can accept a sample
//  data_i          in  width_p            input (dry) sample
//  valid_o         out 1                  output sample valid
//  ready_i         in  1                  downstream accepts output
//  data_o          out width_p            output sample
//  base_delay_i    in  $clog2(depth_p)    nominal delay in samples
//  mod_depth_i     in  $clog2(depth_p)    LFO swing in samples (0 = no modulation)
//  rate_i          in  8                  LFO steps once every rate_i+1 samples
//  ram_wr_valid_o  out 1                  to RAM wr_valid_i
//  ram_wr_data_o   out width_p            to RAM wr_data_i
//  ram_wr_addr_o   out $clog2(depth_p)    to RAM wr_addr_i
//  ram_rd_valid_o  out 1                  to RAM rd_valid_i
//  ram_rd_addr_o   out $clog2(depth_p)    to RAM rd_addr_i
//  ram_rd_data_i   in  width_p            from RAM rd_data_o; valid 1 cycle after the read strobe
// BEHAVIOUR
//  - Reset: state IDLE; wr_ptr=0; fill=0; lfo=0 with direction up; rate counter=0.
//    During reset, valid_o, ready_o and both RAM strobes are 0, and data_o is 0.
//  - FSM: IDLE -> ACCESS -> CAPT -> OUT -> IDLE.
//  - IDLE: ready_o=1. On valid_i&ready_o, latch data_i and compute rd_addr.
//  - Delay computation: d = base_delay_i + lfo, computed 1 bit wider.
//    Saturate d to depth_p-1; force d=0 up to 1.
//    Read address: rd_addr = (wr_ptr - d) mod depth_p.
//  - ACCESS: for one cycle, ram_wr_valid_o=1 (data=latched, addr=wr_ptr) and ram_rd_valid_o=1 (addr=rd_addr).
//    Since d>=1, the read and write never target the same address.
//  - CAPT: sample ram_rd_data_i. wet = (fill >= d) ? ram_rd_data_i : 0, which suppresses stale/uninitialised RAM.
//    Register data_o.
//  - OUT: valid_o=1, with data_o held stable until ready_i. On the handshake:
//    - wr_ptr++ (wraps depth_p-1 -> 0);
//    - fill++ (saturates at depth_p);
//    - LFO update;
//    - go to IDLE.
//  - Latency: sample accepted at cycle T produces valid_o at T+3. Maximum throughput is 1 sample per 4 cycles.
//  - LFO: rate counter counts output handshakes. When it reaches rate_i, it clears and lfo steps by 1 in the current direction.
//    At lfo==mod_depth_i the direction flips down; at lfo==0 it flips up.
//    If mod_depth_i < lfo (changed live): lfo=mod_depth_i and direction=down on the next update.
//  - Controls base_delay_i, mod_depth_i and rate_i are sampled at the accept in IDLE, so changes take effect per sample.
//  - Reset mid-operation (any state): abort. No RAM strobe is issued in the reset cycle, and valid_o drops the next cycle.
// CONFIGURATION
//  CHORUS_DRY_MIX_EN defined:
//    data_o = (dry + wet) >>> 1, using a width_p+1 signed sum and an arithmetic shift that truncates toward -inf.
//  CHORUS_DRY_MIX_EN undefined:
//    data_o = wet only (pure modulated delay); no adder is built.
// TESTING
//  (depth_p=16, width_p=16)
//  1. Fixed delay, no mix: base=4, mod=0. Push 1..10.
//     -> outputs 0,0,0,0,1,2,3,4,5,6; ram_rd_addr for sample 5 = 0.
//  2. Mix (CHORUS_DRY_MIX_EN): wet=20 with dry=100 -> 60; wet=20 with dry=-100 -> -40; wet=-1 with dry=0 -> -1.
//  3. Wrap-around: base=4, push 20 samples.
//     -> wr_addr goes 15 then 0; the 18th sample (wr_ptr=1) reads addr 13 and returns sample 14.
//  4. LFO: base=4, mod=3, rate=0.
//     -> effective delays per sample 4,5,6,7,6,5,4,5; base=14, mod=3 -> delay saturates at 15.
//  5. Backpressure: hold ready_i=0 for 5 cycles in OUT.
//     -> valid_o=1 and data_o stable, ready_o=0, no RAM strobes; the handshake then returns to IDLE.
//  6. Reset in OUT.
//     -> next cycle valid_o=0 and ready_o=1; the next 4 outputs (base=4) have wet=0.

Source files
------------

// File: rtl/chorus_delay_ctrl.sv
// ---------------------------------------------------------------------------
// chorus_delay_ctrl
//
// Initiator side of the chorus delay-line RAM. Each accepted audio sample is
// written into a circular buffer, and the sample "d" entries older is read
// back in the same RAM access. d is the nominal delay plus a triangle LFO
// offset. The block emits the delayed (wet) sample, or a 50/50 dry/wet mix
// when the CHORUS_DRY_MIX_EN macro is defined at build time.
//
// Configuration macro:
//   CHORUS_DRY_MIX_EN  defined   -> data_o = (dry + wet) >>> 1
//                      undefined -> data_o = wet (no adder is built)
//
// Parameters:
//   width_p  sample width, signed two's complement
//   depth_p  delay-line entries, power of 2, must match the attached RAM
//
// Ports:
//   clk_i           single clock
//   reset_i         synchronous, active-high reset
//   valid_i/ready_o input sample handshake, data_i is the dry sample
//   valid_o/ready_i output sample handshake, data_o is the output sample
//   base_delay_i    nominal delay in samples
//   mod_depth_i     LFO swing in samples (0 = no modulation)
//   rate_i          LFO steps once every rate_i+1 output samples
//   ram_wr_*        write port strobe/data/address towards the RAM
//   ram_rd_*        read port strobe/address towards the RAM
//   ram_rd_data_i   read data, valid one cycle after the read strobe
//
// Sample flow: IDLE (accept) -> ACCESS (RAM strobes) -> CAPT (capture read
// data) -> OUT (present until handshake) -> IDLE. One sample per 4 cycles
// at best, output valid 3 cycles after the accept.
// ---------------------------------------------------------------------------
module chorus_delay_ctrl #(
  parameter int width_p = 16,
  parameter int depth_p = 512
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [width_p-1:0]         data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  input  logic [$clog2(depth_p)-1:0] base_delay_i,
  input  logic [$clog2(depth_p)-1:0] mod_depth_i,
  input  logic [7:0]                 rate_i,
  output logic                       ram_wr_valid_o,
  output logic [width_p-1:0]         ram_wr_data_o,
  output logic [$clog2(depth_p)-1:0] ram_wr_addr_o,
  output logic                       ram_rd_valid_o,
  output logic [$clog2(depth_p)-1:0] ram_rd_addr_o,
  input  logic [width_p-1:0]         ram_rd_data_i
);

  localparam int aw_lp = $clog2(depth_p);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPT,
    OUT
  } state_e;

  state_e             state_q;

  // Circular-buffer bookkeeping. fill_q is one bit wider so that it can
  // reach depth_p and stay there once the buffer has been fully written.
  logic [aw_lp-1:0]   wr_ptr_q;
  logic [aw_lp:0]     fill_q;

  // LFO state: current offset, direction, and the handshake counter that
  // divides the LFO step rate.
  logic [aw_lp-1:0]   lfo_q;
  logic               lfo_down_q;
  logic [7:0]         rate_cnt_q;

  // Per-sample context captured at the accept.
  logic [width_p-1:0] dry_q;
  logic [aw_lp-1:0]   delay_q;
  logic [aw_lp-1:0]   rd_addr_q;
  logic [aw_lp-1:0]   mod_q;
  logic [7:0]         rate_q;

  // Registered output flags, decoded from the next state.
  logic [width_p-1:0] data_q;
  logic               valid_q;
  logic               ready_q;
  logic               wr_strobe_q;
  logic               rd_strobe_q;

  // Combinational helpers.
  logic [aw_lp:0]     delay_sum;
  logic [aw_lp-1:0]   delay_next;
  logic [aw_lp-1:0]   rd_addr_next;
  logic [width_p-1:0] wet;
  logic [width_p-1:0] out_sample;
  logic [aw_lp-1:0]   lfo_next;
  logic               lfo_down_next;
  logic [7:0]         rate_cnt_next;
  logic               lfo_tick;

  // Effective delay. The sum is one bit wider so an overflow past the end
  // of the buffer is visible in the top bit; since both operands are below
  // depth_p, that bit alone tells us the sum exceeds depth_p-1. A zero delay
  // is lifted to 1 so the read never collides with the write of the same
  // access.
  assign delay_sum = {1'b0, base_delay_i} + {1'b0, lfo_q};

  always_comb begin
    delay_next = delay_sum[aw_lp-1:0];
    if (delay_sum[aw_lp]) begin
      delay_next = '1;
    end else if (delay_sum == '0) begin
      delay_next = aw_lp'(1);
    end
  end

  // Power-of-2 depth: the natural wrap of the subtraction is the modulo.
  assign rd_addr_next = wr_ptr_q - delay_next;

  // The RAM location is only meaningful once at least delay_q samples have
  // been written since reset; before that it holds stale or uninitialised
  // contents, so the wet path is muted.
  assign wet = (fill_q >= {1'b0, delay_q}) ? ram_rd_data_i : '0;

`ifdef CHORUS_DRY_MIX_EN
  // Dry/wet mix: sign-extended sum, then drop the LSB. Taking bits
  // [width_p:1] of the signed sum is an arithmetic shift right by one that
  // rounds toward minus infinity and always fits back into width_p bits.
  logic signed [width_p:0] mix_sum;

  assign mix_sum    = $signed({dry_q[width_p-1], dry_q}) + $signed({wet[width_p-1], wet});
  assign out_sample = mix_sum[width_p:1];
`else
  assign out_sample = wet;
`endif

  // LFO update applied on each output handshake. The rate counter uses >=
  // so that lowering rate_i between samples can never leave it counting
  // past the new terminal value. If the swing was reduced below the current
  // offset, the offset is clamped to the new swing and the LFO heads down.
  always_comb begin
    lfo_next      = lfo_q;
    lfo_down_next = lfo_down_q;
    lfo_tick      = (rate_cnt_q >= rate_q);
    rate_cnt_next = lfo_tick ? 8'd0 : rate_cnt_q + 8'd1;

    if (mod_q < lfo_q) begin
      lfo_next      = mod_q;
      lfo_down_next = 1'b1;
    end else if (lfo_tick) begin
      if (!lfo_down_q) begin
        if (lfo_q == mod_q) begin
          lfo_down_next = 1'b1;
          lfo_next      = (lfo_q == '0) ? '0 : lfo_q - aw_lp'(1);
        end else begin
          lfo_next = lfo_q + aw_lp'(1);
        end
      end else begin
        if (lfo_q == '0) begin
          lfo_down_next = 1'b0;
          lfo_next      = (mod_q == '0) ? '0 : aw_lp'(1);
        end else begin
          lfo_next = lfo_q - aw_lp'(1);
        end
      end
    end
  end

  // Main sequencer. All outputs are registered flags set alongside the
  // state transition that enters the state they belong to. Reset aborts any
  // sample in flight and returns to an empty buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      lfo_q       <= '0;
      lfo_down_q  <= 1'b0;
      rate_cnt_q  <= '0;
      dry_q       <= '0;
      delay_q     <= '0;
      rd_addr_q   <= '0;
      mod_q       <= '0;
      rate_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            dry_q       <= data_i;
            delay_q     <= delay_next;
            rd_addr_q   <= rd_addr_next;
            mod_q       <= mod_depth_i;
            rate_q      <= rate_i;
            ready_q     <= 1'b0;
            wr_strobe_q <= 1'b1;
            rd_strobe_q <= 1'b1;
            state_q     <= ACCESS;
          end
        end

        ACCESS: begin
          wr_strobe_q <= 1'b0;
          rd_strobe_q <= 1'b0;
          state_q     <= CAPT;
        end

        CAPT: begin
          data_q  <= out_sample;
          valid_q <= 1'b1;
          state_q <= OUT;
        end

        OUT: begin
          if (ready_i) begin
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            wr_ptr_q   <= wr_ptr_q + aw_lp'(1);
            fill_q     <= fill_q[aw_lp] ? fill_q : fill_q + (aw_lp + 1)'(1);
            lfo_q      <= lfo_next;
            lfo_down_q <= lfo_down_next;
            rate_cnt_q <= rate_cnt_next;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The reset input also masks the handshake and strobe outputs directly,
  // so nothing is offered or written during the reset cycle itself even if
  // the sequencer was mid-sample.
  assign ready_o        = ready_q & ~reset_i;
  assign valid_o        = valid_q & ~reset_i;
  assign data_o         = reset_i ? '0 : data_q;
  assign ram_wr_valid_o = wr_strobe_q & ~reset_i;
  assign ram_wr_data_o  = dry_q;
  assign ram_wr_addr_o  = wr_ptr_q;
  assign ram_rd_valid_o = rd_strobe_q & ~reset_i;
  assign ram_rd_addr_o  = rd_addr_q;

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chorus_delay_ctrl
//
// Directed bench for chorus_delay_ctrl with depth_p=16, width_p=16. A small
// behavioural synchronous RAM stands in for ram_1r1w_sync. Expected values
// are hand-derived from the sample index and the delay in each scenario.
// ---------------------------------------------------------------------------
module tb_chorus_delay_ctrl;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk_i;
  logic         reset_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic [3:0]   base_delay_i;
  logic [3:0]   mod_depth_i;
  logic [7:0]   rate_i;
  logic         ram_wr_valid_o;
  logic [W-1:0] ram_wr_data_o;
  logic [3:0]   ram_wr_addr_o;
  logic         ram_rd_valid_o;
  logic [3:0]   ram_rd_addr_o;
  logic [W-1:0] ram_rd_data_i;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mem [D];

  chorus_delay_ctrl #(
    .width_p(W),
    .depth_p(D)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_i         (data_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .base_delay_i   (base_delay_i),
    .mod_depth_i    (mod_depth_i),
    .rate_i         (rate_i),
    .ram_wr_valid_o (ram_wr_valid_o),
    .ram_wr_data_o  (ram_wr_data_o),
    .ram_wr_addr_o  (ram_wr_addr_o),
    .ram_rd_valid_o (ram_rd_valid_o),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram_rd_data_i  (ram_rd_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural RAM: write and registered read in the same cycle.
  always @(posedge clk_i) begin
    if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_valid_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  // Expected output for a given dry sample and wet sample.
  function automatic logic [W-1:0] exp_out(input logic [W-1:0] dry, input logic [W-1:0] wet);
`ifdef CHORUS_DRY_MIX_EN
    logic [W:0] s;
    s = {dry[W-1], dry} + {wet[W-1], wet};
    return s[W:1];
`else
    return wet;
`endif
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  // Offers one sample, returns the read/write addresses seen during the RAM
  // access, the accept-to-valid latency in cycles and the output sample.
  // Completes the output handshake only if ready_i is high.
  task automatic push(input logic [W-1:0] d, output logic [W-1:0] out,
                      output logic [3:0] rda, output logic [3:0] wra, output int lat);
    int n;
    n = 0;
    while (!ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    valid_i = 1'b1;
    data_i  = d;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    data_i  = '0;
    rda = ram_rd_addr_o;
    wra = ram_wr_addr_o;
    lat = 1;
    while (!valid_o && lat < 12) begin
      @(posedge clk_i); #1;
      lat++;
    end
    out = data_o;
    if (ready_i) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (ram_wr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr got=%b exp=0", ram_wr_valid_o); end
    checks++; if (ram_rd_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd got=%b exp=0", ram_rd_valid_o); end
    checks++; if (data_o !== 16'd0) begin failures++; $display("[TB] FAIL reset_data got=%0d exp=0", data_o); end
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", ready_o); end
    checks++; if (ram_wr_addr_o !== 4'd0) begin failures++; $display("[TB] FAIL post_reset_wrptr got=%0d exp=0", ram_wr_addr_o); end
  endtask

  task automatic test_fixed_delay();
    logic [W-1:0] out, wet;
    logic [3:0] rda, wra;
    int lat;
    do_reset();
    base_delay_i = 4'd4; mod_depth_i = 4'd0; rate_i = 8'd0;
    for (int k = 1; k <= 10; k++) begin
      push(W'(k), out, rda, wra, lat);
      wet = (k >= 5) ? W'(k - 4) : '0;
      checks++; if (out !== exp_out(W'(k), wet)) begin failures++; $display("[TB] FAIL fixed_out[%0d] got=%0d exp=%0d", k, $signed(out), $signed(exp_out(W'(k), wet))); end
      checks++; if (wra !== 4'(k - 1)) begin failures++; $display("[TB] FAIL fixed_wraddr[%0d] got=%0d exp=%0d", k, wra, k - 1); end
      if (k == 1) begin
        checks++; if (lat != 3) begin failures++; $display("[TB] FAIL latency got=%0d exp=3", lat); end
      end
      if (k == 5) begin
        checks++; if (rda !== 4'd0) begin failures++; $display("[TB] FAIL fixed_rdaddr5 got=%0d exp=0", rda); end
      end
    end
  endtask

`ifdef CHORUS_DRY_MIX_EN
  task automatic test_mix();
    logic [W-1:0] out;
    logic [3:0] rda, wra;
    int lat;
    logic [W-1:0] wets [3];
    logic [W-1:0] drys [3];
    logic [W-1:0] exps [3];
    wets = '{16'sd20, 16'sd20, -16'sd1};
    drys = '{16'sd100, -16'sd100, 16'sd0};
    exps = '{16'sd60, -16'sd40, -16'sd1};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      base_delay_i = 4'd1; mod_depth_i = 4'd0; rate_i = 8'd0;
      push(wets[i], out, rda, wra, lat);
      push(drys[i], out, rda, wra, lat);
      checks++; if (out !== exps[i]) begin failures++; $display("[TB] FAIL mix[%0d] got=%0d exp=%0d", i, $signed(out), $signed(exps[i])); end
    end
  endtask
`endif

  task automatic test_wrap();
    logic [W-1:0] out;
    logic [3:0] rda, wra;
    int lat;
    do_reset();
    base_delay_i = 4'd4; mod_depth_i = 4'd0; rate_i = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      push(W'(k), out, rda, wra, lat);
      if (k == 16) begin
        checks++; if (wra !== 4'd15) begin failures++; $display("[TB] FAIL wrap_wr16 got=%0d exp=15", wra); end
      end
      if (k == 17) begin
        checks++; if (wra !== 4'd0) begin failures++; $display("[TB] FAIL wrap_wr17 got=%0d exp=0", wra); end
      end
      if (k == 18) begin
        checks++; if (rda !== 4'd13) begin failures++; $display("[TB] FAIL wrap_rd18 got=%0d exp=13", rda); end
        checks++; if (out !== exp_out(16'd18, 16'd14)) begin failures++; $display("[TB] FAIL wrap_out18 got=%0d exp=%0d", out, exp_out(16'd18, 16'd14)); end
      end
      if (k == 20) begin
        checks++; if (out !== exp_out(16'd20, 16'd16)) begin failures++; $display("[TB] FAIL wrap_out20 got=%0d exp=%0d", out, exp_out(16'd20, 16'd16)); end
      end
    end
  endtask

  task automatic test_lfo();
    logic [W-1:0] out;
    logic [3:0] rda, wra, dly;
    int lat;
    int tri_exp [8] = '{4, 5, 6, 7, 6, 5, 4, 5};
    int slow_exp [6] = '{4, 4, 5, 5, 6, 6};
    int sat_exp [4] = '{14, 15, 15, 15};

    do_reset();
    base_delay_i = 4'd4; mod_depth_i = 4'd3; rate_i = 8'd0;
    for (int i = 0; i < 8; i++) begin
      push(W'(100 + i), out, rda, wra, lat);
      dly = wra - rda;
      checks++; if (dly !== 4'(tri_exp[i])) begin failures++; $display("[TB] FAIL lfo_tri[%0d] got=%0d exp=%0d", i, dly, tri_exp[i]); end
    end

    do_reset();
    base_delay_i = 4'd4; mod_depth_i = 4'd3; rate_i = 8'd1;
    for (int i = 0; i < 6; i++) begin
      push(W'(200 + i), out, rda, wra, lat);
      dly = wra - rda;
      checks++; if (dly !== 4'(slow_exp[i])) begin failures++; $display("[TB] FAIL lfo_rate[%0d] got=%0d exp=%0d", i, dly, slow_exp[i]); end
    end

    do_reset();
    base_delay_i = 4'd14; mod_depth_i = 4'd3; rate_i = 8'd0;
    for (int i = 0; i < 4; i++) begin
      push(W'(300 + i), out, rda, wra, lat);
      dly = wra - rda;
      checks++; if (dly !== 4'(sat_exp[i])) begin failures++; $display("[TB] FAIL lfo_sat[%0d] got=%0d exp=%0d", i, dly, sat_exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] out, held;
    logic [3:0] rda, wra;
    int lat;
    do_reset();
    base_delay_i = 4'd1; mod_depth_i = 4'd0; rate_i = 8'd0;
    push(16'd7, out, rda, wra, lat);
    ready_i = 1'b0;
    push(16'd9, held, rda, wra, lat);
    checks++; if (held !== exp_out(16'd9, 16'd7)) begin failures++; $display("[TB] FAIL bp_data got=%0d exp=%0d", held, exp_out(16'd9, 16'd7)); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d] got=%b exp=1", c, valid_o); end
      checks++; if (data_o !== exp_out(16'd9, 16'd7)) begin failures++; $display("[TB] FAIL bp_stable[%0d] got=%0d exp=%0d", c, data_o, exp_out(16'd9, 16'd7)); end
      checks++; if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=0", c, ready_o); end
      checks++; if ((ram_wr_valid_o | ram_rd_valid_o) !== 1'b0) begin failures++; $display("[TB] FAIL bp_strobe[%0d] got=%b exp=0", c, ram_wr_valid_o | ram_rd_valid_o); end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=1", ready_o); end
    push(16'd11, out, rda, wra, lat);
    checks++; if (rda !== 4'd1) begin failures++; $display("[TB] FAIL bp_next_rdaddr got=%0d exp=1", rda); end
    checks++; if (out !== exp_out(16'd11, 16'd9)) begin failures++; $display("[TB] FAIL bp_next_out got=%0d exp=%0d", out, exp_out(16'd11, 16'd9)); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] out;
    logic [3:0] rda, wra;
    int lat;
    do_reset();
    base_delay_i = 4'd4; mod_depth_i = 4'd0; rate_i = 8'd0;
    for (int k = 1; k <= 6; k++) push(W'(k), out, rda, wra, lat);
    ready_i = 1'b0;
    push(16'd7, out, rda, wra, lat);
    reset_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid_during got=%b exp=0", valid_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    ready_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_out_ready got=%b exp=1", ready_o); end

    valid_i = 1'b1;
    data_i  = 16'd50;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    checks++; if ((ram_wr_valid_o | ram_rd_valid_o) !== 1'b0) begin failures++; $display("[TB] FAIL rst_access_strobe got=%b exp=0", ram_wr_valid_o | ram_rd_valid_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_access_ready got=%b exp=1", ready_o); end

    for (int k = 21; k <= 25; k++) begin
      push(W'(k), out, rda, wra, lat);
      if (k < 25) begin
        checks++; if (out !== exp_out(W'(k), 16'd0)) begin failures++; $display("[TB] FAIL rst_muted[%0d] got=%0d exp=%0d", k, out, exp_out(W'(k), 16'd0)); end
      end else begin
        checks++; if (out !== exp_out(16'd25, 16'd21)) begin failures++; $display("[TB] FAIL rst_resume got=%0d exp=%0d", out, exp_out(16'd25, 16'd21)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 16'h5555;
    ram_rd_data_i = '0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i = '0;
    base_delay_i = '0;
    mod_depth_i = '0;
    rate_i = '0;
    test_reset();
    test_fixed_delay();
`ifdef CHORUS_DRY_MIX_EN
    test_mix();
`endif
    test_wrap();
    test_lfo();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
